// File: rtl/combo_lock_core.sv
// combo_lock_core: digit-entry sequencer for a combination lock.
// Accepts one digit per strobe, compares a CODE_LEN-digit attempt with the
// stored code, and limits consecutive failures with a timed lockout.
// Optional feature macro: COMBO_LOCK_PROG_EN (reprogram the code while OPEN).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ENTER   | collecting the digits of an attempt
// OPEN    | correct code entered; waiting for relock (or new code digits)
// FAIL    | last attempt was wrong; next legal digit starts a new attempt
// LOCKOUT | too many consecutive failures; strobes ignored until timer ends
module combo_lock_core #(
    parameter int                            DIGIT_W        = 4,
    parameter int                            MAX_DIGIT      = 9,
    parameter int                            CODE_LEN       = 6,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE           = 24'h946222,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCKOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIGIT_W-1:0]              digit_i,
    input  logic                            digit_valid_i,
    input  logic                            relock_i,
    input  logic                            prog_i,
    output logic                            open_o,
    output logic                            fail_o,
    output logic                            lockout_o,
    output logic                            err_o,
    output logic [$clog2(CODE_LEN+1)-1:0]   pos_o,
    output logic [3:0]                      tries_left_o,
    output logic [DIGIT_W-1:0]              last_digit_o,
    output logic                            prog_done_o
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int POS_W  = $clog2(CODE_LEN + 1);
    localparam int CNT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DIGIT_W-1:0] MAX_D      = DIGIT_W'(MAX_DIGIT);
    localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(CODE_LEN - 1);
    localparam logic [3:0]         TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENTER   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 match_q, match_d;
    logic [3:0]           tries_q, tries_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 open_q, open_d;
    logic                 fail_q, fail_d;
    logic                 lockout_q, lockout_d;
    logic                 err_q, err_d;
    logic [DIGIT_W-1:0]   last_q, last_d;

    logic [CODE_W-1:0]    code_q;
    logic [DIGIT_W-1:0]   exp_digit;
    logic                 digit_legal;
    logic                 attempt_ok;

`ifdef COMBO_LOCK_PROG_EN
    logic [CODE_W-1:0]    code_d;
    logic [CODE_W-1:0]    shadow_q, shadow_d;
    logic [CODE_W-1:0]    shift_in;
    logic                 prog_done_q, prog_done_d;
`endif

    // Select the stored code digit for the current entry position (first digit in the MSBs).
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == POS_W'(i)) begin
                exp_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_legal = (digit_i <= MAX_D);
    // Running match including the digit being strobed now, so the final digit decides in one edge.
    assign attempt_ok  = match_q && (digit_i == exp_digit);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        match_d   = match_q;
        tries_d   = tries_q;
        cnt_d     = cnt_q;
        open_d    = open_q;
        fail_d    = fail_q;
        lockout_d = lockout_q;
        err_d     = err_q;
        last_d    = last_q;
`ifdef COMBO_LOCK_PROG_EN
        code_d      = code_q;
        shadow_d    = shadow_q;
        prog_done_d = 1'b0;
        shift_in    = shadow_q << DIGIT_W;
        shift_in[DIGIT_W-1:0] = digit_i;
`endif
        case (state_q)
            // FAIL behaves like ENTER at position 0; the first legal digit clears fail_o.
            ST_ENTER, ST_FAIL: begin
                if (digit_valid_i) begin
                    if (!digit_legal) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        fail_d  = 1'b0;
                        last_d  = digit_i;
                        state_d = ST_ENTER;
                        if (pos_q == LAST_POS) begin
                            pos_d   = '0;
                            match_d = 1'b1;
                            if (attempt_ok) begin
                                state_d = ST_OPEN;
                                open_d  = 1'b1;
                                tries_d = TRIES_INIT;
                            end else if (tries_q <= 4'd1) begin
                                state_d   = ST_LOCKOUT;
                                lockout_d = 1'b1;
                                fail_d    = 1'b1;
                                tries_d   = 4'd0;
                                cnt_d     = CNT_LOAD;
                            end else begin
                                state_d = ST_FAIL;
                                fail_d  = 1'b1;
                                tries_d = tries_q - 4'd1;
                            end
                        end else begin
                            pos_d   = pos_q + POS_W'(1);
                            match_d = attempt_ok;
                        end
                    end
                end
            end
            // Relock wins over a same-cycle digit; plain digits only update err_o.
            ST_OPEN: begin
                if (relock_i) begin
                    state_d = ST_ENTER;
                    open_d  = 1'b0;
                    pos_d   = '0;
                    match_d = 1'b1;
                end else if (digit_valid_i) begin
                    err_d = !digit_legal;
`ifdef COMBO_LOCK_PROG_EN
                    if (!prog_i) begin
                        pos_d = '0;
                    end else if (digit_legal) begin
                        last_d   = digit_i;
                        shadow_d = shift_in;
                        if (pos_q == LAST_POS) begin
                            code_d      = shift_in;
                            pos_d       = '0;
                            prog_done_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end
`endif
                end
            end
            // Strobes are ignored entirely while the lockout timer runs.
            ST_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_ENTER;
                    lockout_d = 1'b0;
                    fail_d    = 1'b0;
                    tries_d   = TRIES_INIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ENTER;
            end
        endcase
    end

    // State and registered outputs; reset drops any partial entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ENTER;
            pos_q     <= '0;
            match_q   <= 1'b1;
            tries_q   <= TRIES_INIT;
            cnt_q     <= '0;
            open_q    <= 1'b0;
            fail_q    <= 1'b0;
            lockout_q <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            match_q   <= match_d;
            tries_q   <= tries_d;
            cnt_q     <= cnt_d;
            open_q    <= open_d;
            fail_q    <= fail_d;
            lockout_q <= lockout_d;
            err_q     <= err_d;
            last_q    <= last_d;
        end
    end

`ifdef COMBO_LOCK_PROG_EN
    // Programmable code register; reset restores the built-in combination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q      <= CODE;
            shadow_q    <= '0;
            prog_done_q <= 1'b0;
        end else begin
            code_q      <= code_d;
            shadow_q    <= shadow_d;
            prog_done_q <= prog_done_d;
        end
    end

    assign prog_done_o = prog_done_q;
`else
    logic unused_prog;

    assign code_q      = CODE;
    assign prog_done_o = 1'b0;
    assign unused_prog = prog_i;
`endif

    assign open_o       = open_q;
    assign fail_o       = fail_q;
    assign lockout_o    = lockout_q;
    assign err_o        = err_q;
    assign pos_o        = pos_q;
    assign tries_left_o = tries_q;
    assign last_digit_o = last_q;

endmodule

// File: tb/tb_combo_lock_core.sv
// Testbench for combo_lock_core: directed digit sequences checked against an
// attempt-level model (digit queues, failure count, lockout time remaining)
// on every falling edge, plus hand-computed literal expectations.
module tb_combo_lock_core;

    localparam int DIGIT_W        = 4;
    localparam int MAX_DIGIT      = 9;
    localparam int CODE_LEN       = 6;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 8;
    localparam int POS_W          = $clog2(CODE_LEN + 1);
`ifdef COMBO_LOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    localparam int M_ENTER = 0;
    localparam int M_OPEN  = 1;
    localparam int M_LOCK  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [DIGIT_W-1:0] digit_i = '0;
    logic               digit_valid_i = 1'b0;
    logic               relock_i = 1'b0;
    logic               prog_i = 1'b0;
    logic               open_o, fail_o, lockout_o, err_o, prog_done_o;
    logic [POS_W-1:0]   pos_o;
    logic [3:0]         tries_left_o;
    logic [DIGIT_W-1:0] last_digit_o;

    combo_lock_core #(
        .DIGIT_W        (DIGIT_W),
        .MAX_DIGIT      (MAX_DIGIT),
        .CODE_LEN       (CODE_LEN),
        .CODE           (24'h946222),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digit_i       (digit_i),
        .digit_valid_i (digit_valid_i),
        .relock_i      (relock_i),
        .prog_i        (prog_i),
        .open_o        (open_o),
        .fail_o        (fail_o),
        .lockout_o     (lockout_o),
        .err_o         (err_o),
        .pos_o         (pos_o),
        .tries_left_o  (tries_left_o),
        .last_digit_o  (last_digit_o),
        .prog_done_o   (prog_done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // model of the lock at the level of attempts
    int m_mode;
    bit m_fail, m_err, m_pdone;
    int m_last, m_fails, m_lock_left;
    int m_entry[$];
    int m_prog[$];
    int m_code[CODE_LEN];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = M_ENTER; m_fail = 0; m_err = 0; m_pdone = 0;
        m_last = 0; m_fails = 0; m_lock_left = 0;
        m_entry.delete(); m_prog.delete();
        m_code = '{9, 4, 6, 2, 2, 2};
    endtask

    task automatic model_step(input bit dv, input int d, input bit rl, input bit pg);
        bit ok;
        m_pdone = 0;
        if (m_mode == M_LOCK) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_mode = M_ENTER; m_fails = 0; m_fail = 0;
            end
        end else if (m_mode == M_ENTER) begin
            if (dv) begin
                if (d > MAX_DIGIT) m_err = 1;
                else begin
                    m_err = 0; m_fail = 0; m_last = d;
                    m_entry.push_back(d);
                    if (m_entry.size() == CODE_LEN) begin
                        ok = 1;
                        for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 0;
                        m_entry.delete();
                        if (ok) begin
                            m_mode = M_OPEN; m_fails = 0;
                        end else begin
                            m_fails++; m_fail = 1;
                            if (m_fails == MAX_TRIES) begin
                                m_mode = M_LOCK; m_lock_left = LOCKOUT_CYCLES;
                            end
                        end
                    end
                end
            end
        end else begin
            if (rl) begin
                m_mode = M_ENTER; m_prog.delete();
            end else if (dv) begin
                m_err = (d > MAX_DIGIT);
                if (PROG_EN) begin
                    if (!pg) m_prog.delete();
                    else if (d <= MAX_DIGIT) begin
                        m_last = d;
                        m_prog.push_back(d);
                        if (m_prog.size() == CODE_LEN) begin
                            for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog[i];
                            m_prog.delete();
                            m_pdone = 1;
                        end
                    end
                end
            end
        end
    endtask

    // compare DUT against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("open_o",       int'(open_o),       int'(m_mode == M_OPEN));
                chk("lockout_o",    int'(lockout_o),    int'(m_mode == M_LOCK));
                chk("fail_o",       int'(fail_o),       int'(m_fail));
                chk("err_o",        int'(err_o),        int'(m_err));
                chk("pos_o",        int'(pos_o),        (m_mode == M_OPEN) ? m_prog.size() : m_entry.size());
                chk("tries_left_o", int'(tries_left_o), MAX_TRIES - m_fails);
                chk("last_digit_o", int'(last_digit_o), m_last);
                chk("prog_done_o",  int'(prog_done_o),  int'(m_pdone));
            end
        end
    end

    task automatic step(input bit dv, input int d, input bit rl, input bit pg);
        digit_valid_i = dv;
        digit_i       = d[DIGIT_W-1:0];
        relock_i      = rl;
        prog_i        = pg;
        @(posedge clk);
        model_step(dv, d, rl, pg);
        @(negedge clk);
        digit_valid_i = 1'b0;
        relock_i      = 1'b0;
        prog_i        = 1'b0;
    endtask

    task automatic enter_seq(input logic [23:0] s, input bit pg);
        for (int i = 0; i < CODE_LEN; i++) step(1'b1, int'(s[23-4*i -: 4]), 1'b0, pg);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_open"},  int'(open_o), 0);
        chk({tag, "_fail"},  int'(fail_o), 0);
        chk({tag, "_lock"},  int'(lockout_o), 0);
        chk({tag, "_err"},   int'(err_o), 0);
        chk({tag, "_pos"},   int'(pos_o), 0);
        chk({tag, "_tries"}, int'(tries_left_o), 3);
        chk({tag, "_last"},  int'(last_digit_o), 0);
        chk({tag, "_pdone"}, int'(prog_done_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        int lock_cycles;
        #1 rst_n = 1'b0;
        model_reset();
        check_en = 1'b1;
        #1 chk_reset_vals("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // correct code opens the lock; pos steps 1..5 then 0
        for (int i = 0; i < CODE_LEN; i++) begin
            logic [23:0] c;
            c = 24'h946222;
            step(1, int'(c[23-4*i -: 4]), 0, 0);
            chk("open_pos", int'(pos_o), (i + 1) % CODE_LEN);
        end
        chk("open_open", int'(open_o), 1);
        chk("open_tries", int'(tries_left_o), 3);

        // relock and a digit together: relock wins, digit dropped
        step(1, 9, 1, 0);
        chk("relock_open", int'(open_o), 0);
        chk("relock_pos", int'(pos_o), 0);
        chk("relock_last", int'(last_digit_o), 2);
        step(1, 5, 0, 0);
        step(0, 0, 1, 0);
        chk("relock_only_pos", int'(pos_o), 1);

        // restart cleanly via reset-free path: finish that attempt wrongly is avoided,
        // so pulse reset to a clean ENTER
        rst_n = 1'b0; model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // illegal digit sets err without advancing, legal digit clears it
        step(1, 11, 0, 0);
        chk("err_set", int'(err_o), 1);
        chk("err_pos", int'(pos_o), 0);
        step(1, 9, 0, 0);
        chk("err_clr", int'(err_o), 0);
        chk("err_pos1", int'(pos_o), 1);
        chk("err_last", int'(last_digit_o), 9);
        for (int i = 1; i < CODE_LEN; i++) begin
            logic [23:0] c;
            c = 24'h946222;
            step(1, int'(c[23-4*i -: 4]), 0, 0);
        end
        chk("err_open", int'(open_o), 1);
        step(0, 0, 1, 0);

        // one failure, illegal digit in FAIL, then the correct code restores tries
        enter_seq(24'h111111, 0);
        chk("f1_fail", int'(fail_o), 1);
        chk("f1_tries", int'(tries_left_o), 2);
        step(1, 12, 0, 0);
        chk("f1_err", int'(err_o), 1);
        chk("f1_fail_held", int'(fail_o), 1);
        enter_seq(24'h946222, 0);
        chk("f1_open", int'(open_o), 1);
        chk("f1_tries_rst", int'(tries_left_o), 3);
        step(0, 0, 1, 0);

        // three failures lead to an 8-cycle lockout
        enter_seq(24'h111111, 0);
        chk("lk_fail1", int'(fail_o), 1);
        chk("lk_tries1", int'(tries_left_o), 2);
        step(1, 1, 0, 0);
        chk("lk_fail_clr", int'(fail_o), 0);
        for (int i = 1; i < CODE_LEN; i++) step(1, 1, 0, 0);
        chk("lk_fail2", int'(fail_o), 1);
        chk("lk_tries2", int'(tries_left_o), 1);
        enter_seq(24'h111111, 0);
        chk("lk_lock", int'(lockout_o), 1);
        lock_cycles = lockout_o ? 1 : 0;
        for (int k = 0; k < 20 && lockout_o; k++) begin
            step(1, (k % 2) ? 11 : 9, 0, 0);
            if (lockout_o) lock_cycles++;
        end
        chk("lk_cycles", lock_cycles, 8);
        chk("lk_tries3", int'(tries_left_o), 3);
        chk("lk_fail_end", int'(fail_o), 0);
        chk("lk_err", int'(err_o), 0);

        // asynchronous reset mid-attempt
        step(1, 9, 0, 0); step(1, 4, 0, 0); step(1, 6, 0, 0);
        chk("ar_pos", int'(pos_o), 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        enter_seq(24'h946222, 0);
        chk("ar_open", int'(open_o), 1);

`ifdef COMBO_LOCK_PROG_EN
        // abort a program sequence with a plain digit
        step(1, 7, 0, 1); step(1, 8, 0, 1);
        chk("pg_pos2", int'(pos_o), 2);
        step(1, 3, 0, 0);
        chk("pg_abort", int'(pos_o), 0);
        // program 123456
        enter_seq(24'h123456, 1);
        chk("pg_done", int'(prog_done_o), 1);
        chk("pg_open", int'(open_o), 1);
        step(0, 0, 0, 0);
        chk("pg_done_pulse", int'(prog_done_o), 0);
        step(0, 0, 1, 0);
        enter_seq(24'h946222, 0);
        chk("pg_old_fail", int'(fail_o), 1);
        enter_seq(24'h123456, 0);
        chk("pg_new_open", int'(open_o), 1);
`endif
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/combo_lock_core.md
Name: combo_lock_core

Overview:
- Parametrised combination-lock engine: the digit-entry sequencer behind the board-level lock.
- Accepts one digit per strobe and compares a CODE_LEN-digit sequence against a stored code.
- Reports open / fail / error / lockout status, with attempt limiting and timed lockout.
- Display decoding (HEX, LEDR) is done outside this block from its status outputs; at board top, clk comes from a debounced KEY[0] and rst_n from KEY[3].

Parameters:
- DIGIT_W, 4: width of one digit.
- MAX_DIGIT, 9: largest legal digit value; anything above is an entry error.
- CODE_LEN, 6: digits per combination, 1..16.
- CODE, 24'h946222: reset combination, packed CODE_LEN*DIGIT_W bits, first digit in the MSBs.
- MAX_TRIES, 3: consecutive failed attempts before lockout, 1..15.
- LOCKOUT_CYCLES, 1000: clk cycles spent in LOCKOUT, at least 1.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- digit_i, in, DIGIT_W: digit value, sampled when digit_valid_i=1.
- digit_valid_i, in, 1: single-cycle digit strobe.
- relock_i, in, 1: relock request, honoured only in OPEN.
- prog_i, in, 1: program-mode qualifier (see Optional Feature).
- open_o, out, 1: lock open.
- fail_o, out, 1: last completed attempt was wrong.
- lockout_o, out, 1: in LOCKOUT.
- err_o, out, 1: last strobed digit exceeded MAX_DIGIT.
- pos_o, out, $clog2(CODE_LEN+1): digits accepted in the current attempt.
- tries_left_o, out, 4: MAX_TRIES minus consecutive fails.
- last_digit_o, out, DIGIT_W: last legal digit accepted.
- prog_done_o, out, 1: one-cycle pulse when a new code is committed.

Behaviour:
- All outputs are registered.
- Reset values:
  - open_o, fail_o, lockout_o, err_o, prog_done_o = 0.
  - pos_o = 0; last_digit_o = 0; tries_left_o = MAX_TRIES.
  - State = ENTER; code register = CODE.
- Reset is asynchronous and takes effect in any state, mid-attempt included. It discards partial entry and any programmed code.
- States: ENTER, OPEN, FAIL, LOCKOUT.
- Digit legality (any state except LOCKOUT):
  - A strobe with digit_i > MAX_DIGIT sets err_o. The digit is not accepted; pos, match and state are unchanged.
  - A legal strobe clears err_o.
- ENTER:
  - A legal strobe stores last_digit_o, compares the digit against code digit[pos], ANDs the result into a running match flag, and increments pos.
  - When the CODE_LEN-th digit is accepted in cycle N, in cycle N+1: pos_o = 0; the match flag is re-armed to 1.
    - Match → OPEN: open_o = 1, fail_o = 0, tries_left_o = MAX_TRIES.
    - No match → fail count increments.
      - If it reaches MAX_TRIES → LOCKOUT: lockout_o = 1, countdown loaded with LOCKOUT_CYCLES-1.
      - Otherwise → FAIL: fail_o = 1.
- FAIL:
  - A legal strobe clears fail_o, enters ENTER and is processed as digit 0 of the new attempt in the same cycle.
  - An illegal strobe only sets err_o.
- OPEN:
  - A relock_i pulse → ENTER, open_o = 0.
  - relock_i and digit_valid_i in the same cycle: relock wins; the digit is dropped (macro off).
  - Digits without prog_i are ignored.
- LOCKOUT:
  - All strobes are ignored, including err_o evaluation.
  - The countdown decrements each cycle. At 0 → ENTER: lockout_o = 0, tries_left_o = MAX_TRIES, fail_o = 0.
- Only the first CODE_LEN digits count; pos never exceeds CODE_LEN-1 while entering.

Optional Feature:
- Macro: COMBO_LOCK_PROG_EN.
- Defined:
  - In OPEN, legal strobes with prog_i = 1 shift into a shadow register, with their own position counter shown on pos_o.
  - After CODE_LEN digits, the shadow copies into the code register. prog_done_o pulses for 1 cycle and the lock stays OPEN.
  - relock_i, or a strobe with prog_i = 0, mid-program discards the shadow.
  - relock_i takes priority over a same-cycle program digit.
- Not defined:
  - The code is the constant CODE.
  - prog_i is ignored and prog_done_o is tied 0.

Test Plan:
- Reset, then strobe 9,4,6,2,2,2 → pos_o steps 1..5,0; open_o = 1 one cycle after the final strobe; tries_left_o = 3.
- From ENTER, strobe 11 (4'hB) → err_o = 1, pos_o unchanged. Then strobe 9 → err_o = 0, pos_o = 1, last_digit_o = 9.
- Enter 1,1,1,1,1,1 three times, with LOCKOUT_CYCLES=8 for the bench:
  - After attempts 1 and 2: fail_o = 1 and tries_left_o = 2, 1.
  - After attempt 3: lockout_o = 1 for exactly 8 cycles with strobes ignored, then ENTER with tries_left_o = 3.
- Strobe 9,4,6, then pull rst_n low asynchronously between clk edges → all outputs at reset values immediately. Then 9,4,6,2,2,2 → open_o = 1.
- In OPEN, assert relock_i and digit_valid_i together → open_o = 0, pos_o = 0 next cycle.
- With COMBO_LOCK_PROG_EN: in OPEN, prog_i = 1 with 1,2,3,4,5,6 → prog_done_o pulses once. Then relock. Then 9,4,6,2,2,2 → fail_o = 1; 1,2,3,4,5,6 → open_o = 1.
